// File: rtl/secded_err_monitor_pkg.sv
// Shared types and tables for the SECDED error monitor: alarm FSM states,
// hex-to-7-segment glyphs (a..g on bits 0..6, active-high) and display slot encoding.
package secded_err_monitor_pkg;

  typedef enum logic {NORMAL = 1'b0, ALARM = 1'b1} state_t;

  typedef enum logic [1:0] {SLOT_D1 = 2'd0, SLOT_D2 = 2'd1, SLOT_D3 = 2'd2} slot_t;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    return HEX_SEG[v];
  endfunction

  function automatic slot_t next_slot(input slot_t s);
    case (s)
      SLOT_D1: return SLOT_D2;
      SLOT_D2: return SLOT_D3;
      default: return SLOT_D1;
    endcase
  endfunction

endpackage

// File: rtl/secded_err_monitor_if.sv
// Decoded-word input stream and forwarded-word output stream of the error monitor.
// master = upstream decoder / downstream sink side, slave = the monitor.
interface secded_err_monitor_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_1bit_error;
  logic       in_2bit_error;
  logic       in_parity_error;
  logic [6:0] in_symptom;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;

  modport master (
    output in_valid, in_data, in_1bit_error, in_2bit_error, in_parity_error, in_symptom,
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_1bit_error, in_2bit_error, in_parity_error, in_symptom,
    input  out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/seg_digit_mux.sv
// Three-digit multiplexed 7-segment driver: scan counter, one-hot anode rotation,
// glyph selection and alarm blink of digit 3 on alternate scan rounds.
module seg_digit_mux
  import secded_err_monitor_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dig1_val,
  input  logic [3:0] dig2_val,
  input  logic [3:0] dig3_val,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic       an1,
  output logic       an2,
  output logic       an3
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] scan_cnt;
  slot_t            slot;
  logic             blink_ph;

  // blink_ph flips once per full D1->D2->D3 round
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      slot     <= SLOT_D1;
      blink_ph <= 1'b0;
    end else if (scan_cnt == DIV_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      slot     <= next_slot(slot);
      if (slot == SLOT_D3) blink_ph <= ~blink_ph;
    end else begin
      scan_cnt <= scan_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    seg = '0;
    case (slot)
      SLOT_D1: seg = hex_seg(dig1_val);
      SLOT_D2: seg = hex_seg(dig2_val);
      SLOT_D3: seg = (blink_en && blink_ph) ? 7'h00 : hex_seg(dig3_val);
      default: seg = '0;
    endcase
  end

  assign an1 = (slot == SLOT_D1);
  assign an2 = (slot == SLOT_D2);
  assign an3 = (slot == SLOT_D3);

endmodule

// File: rtl/secded_err_monitor.sv
// SECDED decoder error monitor: forwards correctable words, drops uncorrectable ones,
// counts errors, latches sticky alarm. Build option: ERR_CNT_SATURATE_EN (saturating counters).
module secded_err_monitor
  import secded_err_monitor_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_clear,
  secded_err_monitor_if.slave   bus,
  output logic [CNT_W-1:0]      out_corr_cnt,
  output logic [CNT_W-1:0]      out_uncorr_cnt,
  output logic                  out_alarm,
  output logic [6:0]            out_7seg,
  output logic                  anode1_active,
  output logic                  anode2_active,
  output logic                  anode3_active
);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef ERR_CNT_SATURATE_EN
    return (&c) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  // Position of the highest flipped codeword bit, 1-based; 0 when none flipped.
  function automatic logic [2:0] sym_pos(input logic [6:0] s);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < 7; i++)
      if (s[i]) p = 3'(i + 1);
    return p;
  endfunction

  logic             vld_p1;
  logic [3:0]       data_p1;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;
  logic [2:0]       last_pos;
  state_t           state;
  logic             alarm_q;
  logic             acc;
  logic             fwd;
  logic             any_err;

  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  assign fwd          = acc && !bus.in_2bit_error;
  assign any_err      = bus.in_1bit_error || bus.in_2bit_error || bus.in_parity_error;

  // Stage p1: one-entry output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (fwd) begin
      vld_p1  <= 1'b1;
      data_p1 <= bus.in_data;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Error bookkeeping and alarm FSM; clear wins over a coincident error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      last_pos   <= '0;
      state      <= NORMAL;
      alarm_q    <= 1'b0;
    end else if (in_clear) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      last_pos   <= '0;
      state      <= NORMAL;
      alarm_q    <= 1'b0;
    end else if (acc) begin
      if (bus.in_1bit_error) corr_cnt <= cnt_inc(corr_cnt);
      if (any_err) last_pos <= sym_pos(bus.in_symptom);
      case (state)
        NORMAL: if (bus.in_2bit_error) begin
          uncorr_cnt <= cnt_inc(uncorr_cnt);
          state      <= ALARM;
          alarm_q    <= 1'b1;
        end
        ALARM: if (bus.in_2bit_error) uncorr_cnt <= cnt_inc(uncorr_cnt);
        default: begin
          state   <= NORMAL;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.out_data   = data_p1;
  assign out_corr_cnt   = corr_cnt;
  assign out_uncorr_cnt = uncorr_cnt;
  assign out_alarm      = alarm_q;

  seg_digit_mux #(.SCAN_DIV(SCAN_DIV)) u_seg (
    .clk      (clk),
    .rst_n    (rst_n),
    .dig1_val (corr_cnt[3:0]),
    .dig2_val (uncorr_cnt[3:0]),
    .dig3_val ({1'b0, last_pos}),
    .blink_en (alarm_q),
    .seg      (out_7seg),
    .an1      (anode1_active),
    .an2      (anode2_active),
    .an3      (anode3_active)
  );

endmodule

// File: tb/tb_secded_err_monitor.sv
// Directed testbench for secded_err_monitor (CNT_W=8, SCAN_DIV=4).
module tb_secded_err_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_clear = 1'b0;
  logic [7:0] corr_cnt, uncorr_cnt;
  logic       alarm;
  logic [6:0] seg;
  logic       an1, an2, an3;
  int         n_tests = 0;
  int         n_fail  = 0;

  secded_err_monitor_if bus ();

  secded_err_monitor #(.CNT_W(8), .SCAN_DIV(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_clear       (in_clear),
    .bus            (bus.slave),
    .out_corr_cnt   (corr_cnt),
    .out_uncorr_cnt (uncorr_cnt),
    .out_alarm      (alarm),
    .out_7seg       (seg),
    .anode1_active  (an1),
    .anode2_active  (an2),
    .anode3_active  (an3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid        = 1'b0;
    bus.in_data         = 4'h0;
    bus.in_1bit_error   = 1'b0;
    bus.in_2bit_error   = 1'b0;
    bus.in_parity_error = 1'b0;
    bus.in_symptom      = 7'h00;
  endtask

  function automatic logic anode(input int which);
    case (which)
      1: return an1;
      2: return an2;
      default: return an3;
    endcase
  endfunction

  // Waits (bounded) for a negedge at which the given anode has just become active.
  task automatic wait_slot_rise(input int which, output bit ok);
    logic prev, cur;
    ok = 1'b0;
    @(negedge clk);
    prev = anode(which);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cur = anode(which);
      if (cur && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0) begin
      n_fail++; $display("FAIL reset_out: valid=%b data=%h want 0/0", bus.out_valid, bus.out_data);
    end
    n_tests++;
    if (corr_cnt !== 8'h00 || uncorr_cnt !== 8'h00 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL reset_cnt: corr=%h uncorr=%h alarm=%b want 0/0/0", corr_cnt, uncorr_cnt, alarm);
    end
    n_tests++;
    if ({an1, an2, an3} !== 3'b100 || seg !== 7'h3F) begin
      n_fail++; $display("FAIL reset_disp: anodes=%b seg=%h want 100/3f", {an1, an2, an3}, seg);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_clean_word();
    bus.in_valid = 1'b1; bus.in_data = 4'hA;
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA) begin
      n_fail++; $display("FAIL clean_fwd: valid=%b data=%h want 1/a", bus.out_valid, bus.out_data);
    end
    n_tests++;
    if (corr_cnt !== 8'h00 || uncorr_cnt !== 8'h00) begin
      n_fail++; $display("FAIL clean_cnt: corr=%h uncorr=%h want 0/0", corr_cnt, uncorr_cnt);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clean_drain: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_corr_error();
    bit ok;
    bus.in_valid = 1'b1; bus.in_data = 4'h3;
    bus.in_1bit_error = 1'b1; bus.in_symptom = 7'b0010000;
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h3 || corr_cnt !== 8'h01) begin
      n_fail++; $display("FAIL corr_fwd: valid=%b data=%h corr=%h want 1/3/01", bus.out_valid, bus.out_data, corr_cnt);
    end
    wait_slot_rise(3, ok);
    n_tests++;
    if (!ok || seg !== 7'h6D) begin
      n_fail++; $display("FAIL corr_digit3: seen=%b seg=%h want 1/6d", ok, seg);
    end
    step();
  endtask

  task automatic test_parity_only();
    bit ok;
    bus.in_valid = 1'b1; bus.in_data = 4'h4;
    bus.in_parity_error = 1'b1; bus.in_symptom = 7'h00;
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h4 || corr_cnt !== 8'h01 || uncorr_cnt !== 8'h00) begin
      n_fail++; $display("FAIL parity_fwd: valid=%b data=%h corr=%h uncorr=%h want 1/4/01/00",
                         bus.out_valid, bus.out_data, corr_cnt, uncorr_cnt);
    end
    wait_slot_rise(3, ok);
    n_tests++;
    if (!ok || seg !== 7'h3F) begin
      n_fail++; $display("FAIL parity_digit3: seen=%b seg=%h want 1/3f", ok, seg);
    end
    step();
  endtask

  task automatic test_uncorr_alarm();
    bit ok;
    logic [6:0] s1, s2;
    bus.in_valid = 1'b1; bus.in_data = 4'h7;
    bus.in_2bit_error = 1'b1; bus.in_symptom = 7'b0000011;
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || uncorr_cnt !== 8'h01 || alarm !== 1'b1) begin
      n_fail++; $display("FAIL uncorr_drop: valid=%b uncorr=%h alarm=%b want 0/01/1", bus.out_valid, uncorr_cnt, alarm);
    end
    wait_slot_rise(3, ok);
    s1 = seg;
    wait_slot_rise(3, ok);
    s2 = seg;
    n_tests++;
    if (!ok || !((s1 === 7'h5B && s2 === 7'h00) || (s1 === 7'h00 && s2 === 7'h5B))) begin
      n_fail++; $display("FAIL uncorr_blink: seen=%b round1=%h round2=%h want 5b/00 alternating", ok, s1, s2);
    end
    wait_slot_rise(1, ok);
    s1 = seg;
    wait_slot_rise(1, ok);
    s2 = seg;
    n_tests++;
    if (!ok || s1 !== 7'h06 || s2 !== 7'h06) begin
      n_fail++; $display("FAIL alarm_digit1: seen=%b round1=%h round2=%h want 06/06", ok, s1, s2);
    end
    step();
    in_clear = 1'b1;
    step();
    in_clear = 1'b0;
    @(negedge clk);
    n_tests++;
    if (corr_cnt !== 8'h00 || uncorr_cnt !== 8'h00 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL clear: corr=%h uncorr=%h alarm=%b want 0/0/0", corr_cnt, uncorr_cnt, alarm);
    end
    step();
  endtask

  task automatic test_clear_priority();
    in_clear = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 4'h5; bus.in_2bit_error = 1'b1; bus.in_symptom = 7'b1000000;
    step();
    bus.in_2bit_error = 1'b0; bus.in_1bit_error = 1'b1; bus.in_data = 4'hC;
    @(negedge clk);
    n_tests++;
    if (uncorr_cnt !== 8'h00 || alarm !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_prio_2bit: uncorr=%h alarm=%b valid=%b want 00/0/0", uncorr_cnt, alarm, bus.out_valid);
    end
    step();
    in_clear = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hC || corr_cnt !== 8'h00) begin
      n_fail++; $display("FAIL clr_prio_fwd: valid=%b data=%h corr=%h want 1/c/00", bus.out_valid, bus.out_data, corr_cnt);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'h1;
    step();
    bus.in_data = 4'h2;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: valid=%b data=%h in_ready=%b want 1/1/0", bus.out_valid, bus.out_data, bus.in_ready);
    end
    step();
    step();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h1) begin
      n_fail++; $display("FAIL bp_stall: valid=%b data=%h want 1/1", bus.out_valid, bus.out_data);
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready: in_ready=%b want 1", bus.in_ready);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h2) begin
      n_fail++; $display("FAIL bp_second: valid=%b data=%h want 1/2", bus.out_valid, bus.out_data);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_dup: valid=%b want 0", bus.out_valid);
    end
    step();
  endtask

  task automatic test_count_limit();
    logic [7:0] exp_final;
`ifdef ERR_CNT_SATURATE_EN
    exp_final = 8'hFF;
`else
    exp_final = 8'h00;
`endif
    bus.in_valid = 1'b1; bus.in_data = 4'h6;
    bus.in_1bit_error = 1'b1; bus.in_symptom = 7'b0000001;
    repeat (255) step();
    @(negedge clk);
    n_tests++;
    if (corr_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL cnt_255: corr=%h want ff", corr_cnt);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (corr_cnt !== exp_final || uncorr_cnt !== 8'h00) begin
      n_fail++; $display("FAIL cnt_256: corr=%h uncorr=%h want %h/00", corr_cnt, uncorr_cnt, exp_final);
    end
    step();
  endtask

  task automatic test_scan();
    bit ok;
    bit rot_ok;
    wait_slot_rise(2, ok);
    rot_ok = ok && ({an1, an2, an3} === 3'b010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({an1, an2, an3} !== 3'b010) rot_ok = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (!rot_ok || {an1, an2, an3} !== 3'b001) begin
      n_fail++; $display("FAIL scan_rotate: held=%b anodes=%b want 1/001", rot_ok, {an1, an2, an3});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({an1, an2, an3} !== 3'b100 || seg !== 7'h3F) begin
      n_fail++; $display("FAIL scan_reset: anodes=%b seg=%h want 100/3f", {an1, an2, an3}, seg);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_transfer();
    bit stayed_idle;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'h9;
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h9) begin
      n_fail++; $display("FAIL mid_hold: valid=%b data=%h want 1/9", bus.out_valid, bus.out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0) begin
      n_fail++; $display("FAIL mid_reset: valid=%b data=%h want 0/0", bus.out_valid, bus.out_data);
    end
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stayed_idle = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stayed_idle = 1'b0;
    end
    n_tests++;
    if (!stayed_idle) begin
      n_fail++; $display("FAIL mid_discard: word reappeared after reset, want none");
    end
  endtask

  initial begin
    idle_inputs();
    bus.out_ready = 1'b1;
    test_reset();
    test_clean_word();
    test_corr_error();
    test_parity_only();
    test_uncorr_alarm();
    test_clear_priority();
    test_back_to_back();
    test_count_limit();
    test_scan();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
